imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised RV64I/RV32I immediate generator for the decode stage.
//  - Accepts instruction words over a valid/ready handshake.
//  - Decodes the format from the opcode and sign-extends the immediate to XLEN.
//  - Buffers results in a 2-entry output queue so decode back-pressure never drops an instruction.
//  - Extends the combinational generator with U/J formats, format/illegal reporting, tag passthrough and flow control.
// PARAMETERS
//  XLEN   64  immediate output width; legal values 32 or 64
//  TAG_W  5   width of sideband tag (e.g. rd/ROB index) carried alongside each instruction
//  CNT_W  32  width of the optional transfer counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       instr/in_tag valid
//  in_ready   out  1       block can accept this cycle
//  instr      in   32      instruction word
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       head entry valid
//  out_ready  in   1       consumer accepts head entry
//  imm        out  XLEN    sign-extended immediate of head entry
//  fmt        out  3       0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
//  illegal    out  1       head opcode not in the supported set
//  out_tag    out  TAG_W   tag of head entry
//  perf_cnt   out  CNT_W   completed transfers (present only with IMM_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (async on rst_n low): queue count=0, out_valid=0, imm=0, fmt=0, illegal=0, out_tag=0, perf_cnt=0; in_ready=1 after release.
//  - Push when in_valid&&in_ready. Pop when out_valid&&out_ready. in_ready = (count<2). out_valid = (count!=0).
//  - Latency: word pushed into an empty queue appears on outputs the next cycle; no combinational in->out path.
//  - Head outputs stay stable while out_valid&&!out_ready.
//  - Simultaneous push+pop at count=1: count stays 1; new entry becomes head next cycle.
//  - At count=2, in_ready=0; a same-cycle pop does not enable a push (no ready-on-pop bypass).
//  - Format decode on opcode[6:0]:
//    - 0010011/0000011/1100111/0011011 -> I
//    - 0100011 -> S
//    - 1100011 -> B
//    - 0110111/0010111 -> U
//    - 1101111 -> J
//    - 0110011/0111011 -> R
//    - else -> fmt=7, illegal=1
//  - Immediate fields:
//    - I: instr[31:20]
//    - S: {instr[31:25],instr[11:7]}
//    - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//    - U: {instr[31:12],12'b0}
//    - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//    - All formats sign-extended from the field MSB to XLEN.
//    - R and unknown formats give imm=0.
//  - Decode happens at push; queue stores the decoded imm/fmt/illegal/tag, not the raw instr.
//  - rst_n asserted mid-operation: all queued entries discarded immediately; no partial output.
// CONFIGURATION
//  IMM_PERF_CNT_EN defined:
//    - perf_cnt port exists.
//    - Increments by 1 on every pop; saturates at all-ones; cleared only by reset.
//  IMM_PERF_CNT_EN undefined:
//    - perf_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  - I-type: push 0x00210013, then 0x01043003 with out_ready=1 -> imm=2 fmt=1, then imm=16 fmt=1, each 1 cycle after push.
//  - S/B-type:
//    - push 0x00530823 -> imm=16 fmt=2.
//    - push 0xFE010CE3 -> imm=-8 (all-ones upper bits) fmt=3.
//    - push 0x00428463 -> imm=8 fmt=3.
//  - U/J/R/unknown:
//    - 0x123450B7 -> imm=0x12345000 fmt=4.
//    - 0xFFDFF0EF -> imm=-4 fmt=5.
//    - 0x002081B3 -> imm=0 fmt=0 illegal=0.
//    - 0x0000007F -> fmt=7 illegal=1 imm=0.
//  - Back-pressure:
//    - Hold out_ready=0 and push 3 words with tags 1,2,3 -> in_ready drops after 2 pushes; third held by source.
//    - Release out_ready -> tags emerge 1,2,3 in order, head stable while stalled.
//  - Reset mid-stream: assert rst_n low with count=2 -> out_valid=0 and imm=0 immediately, in_ready=1 after release, perf_cnt=0.
//  - XLEN=32 build plus IMM_PERF_CNT_EN:
//    - 0xFE010CE3 -> imm=32'hFFFFFFF8.
//    - 5 pops -> perf_cnt=5.
//    - With CNT_W=2, 5 pops -> perf_cnt=3 (saturated).

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator with a 2-entry output queue.
// Define IMM_PERF_CNT_EN to add the saturating perf_cnt transfer counter.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
`ifdef IMM_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_cnt,
`endif
    output logic [TAG_W-1:0] out_tag
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t      d, e0, e1;
    logic [1:0]  count;
    logic [6:0]  op;
    logic [2:0]  dfmt;
    logic [31:0] imm32;
    logic        push, pop;

    assign op        = instr[6:0];
    assign in_ready  = count < 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign imm       = e0.imm;
    assign fmt       = e0.fmt;
    assign illegal   = e0.ill;
    assign out_tag   = e0.tag;

    always_comb begin
        dfmt  = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b0011011) ? 3'd1 :
                (op == 7'b0100011) ? 3'd2 :
                (op == 7'b1100011) ? 3'd3 :
                (op == 7'b0110111 || op == 7'b0010111) ? 3'd4 :
                (op == 7'b1101111) ? 3'd5 :
                (op == 7'b0110011 || op == 7'b0111011) ? 3'd0 : 3'd7;
        imm32 = (dfmt == 3'd1) ? {{20{instr[31]}}, instr[31:20]} :
                (dfmt == 3'd2) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                (dfmt == 3'd3) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                (dfmt == 3'd4) ? {instr[31:12], 12'b0} :
                (dfmt == 3'd5) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'd0;
        d.imm = XLEN'($signed(imm32));
        d.fmt = dfmt;
        d.ill = dfmt == 3'd7;
        d.tag = in_tag;
    end

    // e0 is always the head; e1 only holds the second entry when two are queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                e0 <= d;
            else if (pop)
                e0 <= e1;
            if (push && count == 2'd1 && !pop)
                e1 <= d;
        end
    end

`ifdef IMM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if (pop && !(&perf_cnt))
            perf_cnt <= perf_cnt + 1'b1;
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule
